// File: rtl/apb_req_master_pkg.sv
// apb_req_master_pkg
//   Shared types for the APB request master: FSM state encoding, the
//   response record returned to the request client, and the word-alignment
//   mask applied to incoming request addresses.
package apb_req_master_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/apb_req_master_tmo.sv
// apb_req_master_tmo
//   ACCESS-phase stall counter. Cleared while the master is in SETUP and
//   incremented on every ACCESS cycle that sees PREADY low. 'expired' is
//   combinational and flags the cycle whose increment would reach 'limit',
//   i.e. the limit-th consecutive stalled ACCESS cycle.
// Ports:
//   HCLK, HRESETn  clock, asynchronous active-low reset
//   clr            clear counter (priority over inc)
//   inc            count one stalled ACCESS cycle
//   limit          abort threshold in stalled cycles (>= 1)
//   expired        this stalled cycle is the limit-th one
module apb_req_master_tmo #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = inc && ((cnt + CNT_W'(1)) == limit);

endmodule

// File: rtl/apb_req_master.sv
// apb_req_master
//   APB3 initiator: turns a valid/ready request into one APB transfer at a
//   time and returns read data plus error status on a valid/ready response
//   channel. Misaligned requests are answered with an error and never reach
//   the bus.
//   Optional feature macro: APB_REQ_MASTER_TIMEOUT_EN. When defined, an
//   ACCESS phase stalled for TIMEOUT_CYCLES cycles is aborted with err=1.
//   When undefined, ACCESS waits for PREADY indefinitely and no counter
//   exists.
// Ports:
//   HCLK, HRESETn                  clock, asynchronous active-low reset
//   req_valid_i/req_ready_o        request handshake (ready decoded from IDLE)
//   req_addr_i/wdata_i/write_i     request payload
//   rsp_valid_o/rsp_ready_i        response handshake
//   rsp_rdata_o/rsp_err_o          response payload
//   PADDR/PWDATA/PWRITE/PSEL/PENABLE  APB requester outputs (registered)
//   PRDATA/PREADY/PSLVERR          APB completer inputs
module apb_req_master
    import apb_req_master_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]               req_wdata_i,
    input  logic                      req_write_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [31:0]               rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    state_t state;
    rsp_t   rsp_q;
    logic   tmo_expired;

`ifdef APB_REQ_MASTER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic tmo_clr;
    logic tmo_inc;

    assign tmo_clr = (state == SETUP);
    assign tmo_inc = (state == ACCESS) && !PREADY;

    apb_req_master_tmo #(
        .CNT_W (TMO_W)
    ) u_tmo (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .clr     (tmo_clr),
        .inc     (tmo_inc),
        .limit   (TMO_W'(TIMEOUT_CYCLES)),
        .expired (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    assign req_ready_o = (state == IDLE);
    assign rsp_rdata_o = rsp_q.rdata;
    assign rsp_err_o   = rsp_q.err;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state       <= IDLE;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid_o <= 1'b0;
            rsp_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        PADDR  <= req_addr_i;
                        PWDATA <= req_wdata_i;
                        PWRITE <= req_write_i;
                        if (is_misaligned(req_addr_i[1:0])) begin
                            rsp_q.rdata <= '0;
                            rsp_q.err   <= 1'b1;
                            rsp_valid_o <= 1'b1;
                            state       <= RESP;
                        end else begin
                            PSEL  <= 1'b1;
                            state <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // Completion is checked first so PREADY in the final
                    // allowed cycle beats the timeout abort.
                    if (PREADY) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_q.rdata <= PWRITE ? '0 : PRDATA;
                        rsp_q.err   <= PSLVERR;
                        rsp_valid_o <= 1'b1;
                        state       <= RESP;
                    end else if (tmo_expired) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_q.rdata <= '0;
                        rsp_q.err   <= 1'b1;
                        rsp_valid_o <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/apb_req_master.md
# apb_req_master

APB3 initiator that converts a simple valid/ready request/response interface into single APB transfers toward peripherals such as the APB timer. It sits between an internal bus client (debug port, DMA control, test sequencer) and an APB peripheral's PSEL/PENABLE/PREADY port. It issues one transfer at a time, returns read data and error status, and can abort transfers that stall.

## Interface
- APB_ADDR_WIDTH, 12, width of PADDR and req_addr_i.
- TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles before abort; must be ≥1.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  request accepted this cycle when high with req_valid_i.
- req_addr_i  in  APB_ADDR_WIDTH  byte address; must be word-aligned.
- req_wdata_i  in  32  write data.
- req_write_i  in  1  1 = write, 0 = read.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed.
- rsp_rdata_o  out  32  read data; 0 for writes and errors without data.
- rsp_err_o  out  1  PSLVERR, misalignment or timeout.
- PADDR  out  APB_ADDR_WIDTH  APB address.
- PWDATA  out  32  APB write data.
- PWRITE  out  1  APB direction.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- **IDLE**
  - req_ready_o=1.
  - On req_valid_i, latch addr, wdata and write.
  - If req_addr_i[1:0]≠0, go to RESP with err=1 and rdata=0. No bus activity occurs.
  - Otherwise go to SETUP.
- **SETUP**
  - PSEL=1, PENABLE=0.
  - Always exactly one cycle, then ACCESS.
- **ACCESS**
  - PSEL=1, PENABLE=1.
  - On PREADY=1:
    - capture rdata=PRDATA for reads, 0 for writes;
    - set err=PSLVERR;
    - go to RESP.
  - Otherwise stay in ACCESS.
- **RESP**
  - rsp_valid_o=1; rdata and err are held stable until rsp_ready_i.
  - On rsp_ready_i, go to IDLE.
- PADDR, PWDATA and PWRITE come from the latch and change only on request acceptance. They hold their last values in IDLE and RESP.
- All outputs are registered except req_ready_o, which is decoded from state.
- Reset values: PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, req_ready_o=1.
- Reset mid-operation drops PSEL and PENABLE asynchronously and discards the in-flight transfer and any pending response.

## Timing
- Accept in cycle 0, SETUP in cycle 1, ACCESS in cycle 2.
- With PREADY=1 in cycle 2, rsp_valid_o=1 in cycle 3.
- Each wait state (PREADY=0) adds one cycle.
- Minimum spacing is 4 cycles per transfer with rsp_ready_i tied high. The next request is accepted in the cycle after the RESP handshake.
- Misaligned request: rsp_valid_o=1 in cycle 1.
- Timeout:
  - The counter clears on SETUP and increments on each ACCESS cycle with PREADY=0.
  - If PREADY=0 in the TIMEOUT_CYCLES-th ACCESS cycle, the transfer aborts: PSEL and PENABLE are 0 next cycle, RESP is entered with err=1 and rdata=0.
  - If PREADY=1 in that same cycle, completion wins over timeout.
- The counter width is $clog2(TIMEOUT_CYCLES+1).

## Configuration
- Macro APB_REQ_MASTER_TIMEOUT_EN.
- Defined: the timeout counter and abort path are present, as described above.
- Undefined:
  - ACCESS waits indefinitely for PREADY;
  - TIMEOUT_CYCLES is ignored;
  - no counter flops are instantiated;
  - rsp_err_o sources are PSLVERR and misalignment only.

## Structure
- Package apb_req_master_pkg holds:
  - the state enum typedef (IDLE/SETUP/ACCESS/RESP);
  - a response struct typedef {rdata[31:0], err};
  - a localparam for the alignment mask.
- One sub-module, apb_req_master_tmo, is the timeout counter with inputs clr, inc and limit and output expired. It is instantiated only under APB_REQ_MASTER_TIMEOUT_EN.

## Test plan
- **Write:** write 0x0000_0009 to 0x004 against the APB timer slave → PSEL in cycle 1, PENABLE in cycle 2, rsp_valid_o in cycle 3, err=0, rdata=0. The slave's ctrl register then reads 0x9.
- **Read:** write 0x0000_0100 to 0x008, then read 0x008 → rsp_rdata_o=0x0000_0100, err=0.
- **Misaligned:** request to 0x006 → PSEL never asserts, rsp_valid_o in cycle 1 with err=1 and rdata=0.
- **Timeout:** TIMEOUT_CYCLES=4, PREADY held 0 → PENABLE high exactly 4 cycles, then err=1 and rdata=0. The same test with PREADY=1 in the 4th cycle → normal completion, err=0.
- **Slave error and backpressure:** PREADY=1 with PSLVERR=1 on a read with PRDATA=0xDEAD_BEEF → err=1, rdata=0xDEAD_BEEF. With rsp_ready_i low for 5 cycles, the response stays stable and req_ready_o stays 0.
- **Reset mid-transfer:** HRESETn low during ACCESS → PSEL and PENABLE drop to 0 before the next HCLK edge. After release, rsp_valid_o=0 and req_ready_o=1.
